// File: rtl/spi_slave_rx.sv
// SPI receive stage: oversamples cs/sclk/mosi on clk, deserializes MSB-first
// words and hands each completed word to a valid/ready consumer. Aborted
// frames raise a one-cycle frame_err; words that find dout still occupied
// are dropped and set the sticky overrun flag.
module spi_slave_rx #(
    parameter int DATA_W = 12,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs,
    input  logic                      sclk,
    input  logic                      mosi,
    output logic [DATA_W-1:0]         dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      overrun_clr,
    output logic                      busy,
    output logic [$clog2(DATA_W)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic SCLK_IDLE   = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);
    // Synchronizer reset image, bit order {mosi, sclk, cs}
    localparam logic [2:0] SYNC_RST = {1'b0, SCLK_IDLE, 1'b0};
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [2:0] sync_in;
    logic [2:0] sync_s2;
    logic [1:0] sync_s3_reg;

    assign sync_in = {mosi, sclk, cs};

    // Equal-depth two-flop synchronizers keep mosi aligned with sclk
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            // Two-stage metastability filter for one asynchronous input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= SYNC_RST[gi];
                    s2_reg <= SYNC_RST[gi];
                end else begin
                    s1_reg <= sync_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign sync_s2[gi] = s2_reg;
        end
    endgenerate

    // Previous synchronized cs/sclk for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s3_reg <= SYNC_RST[1:0];
        end else begin
            sync_s3_reg <= sync_s2[1:0];
        end
    end

    logic cs_s2, sclk_s2, mosi_s2, cs_s3, sclk_s3;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall, sample_edge;

    assign cs_s2       = sync_s2[0];
    assign sclk_s2     = sync_s2[1];
    assign mosi_s2     = sync_s2[2];
    assign cs_s3       = sync_s3_reg[0];
    assign sclk_s3     = sync_s3_reg[1];
    assign cs_rise     = cs_s2 & ~cs_s3;
    assign cs_fall     = ~cs_s2 & cs_s3;
    assign sclk_rise   = sclk_s2 & ~sclk_s3;
    assign sclk_fall   = ~sclk_s2 & sclk_s3;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

    logic [0:0]        state_reg, state_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] word_reg, word_next;
    logic              pend_reg, pend_next;
    logic              ferr_reg, ferr_next;

    // Frame FSM: shift on sample edges, detect word completion and aborts.
    // A completed word is parked in word_reg so the commit a cycle later
    // cannot be disturbed by a new frame clearing the shift register.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        word_next    = word_reg;
        pend_next    = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cs_rise) begin
                    bit_cnt_next = '0;
                    shift_next   = '0;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    shift_next = {shift_reg[DATA_W-2:0], mosi_s2};
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        word_next    = {shift_reg[DATA_W-2:0], mosi_s2};
                        pend_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                // A final bit landing together with cs release still commits
                if (cs_fall) begin
                    state_next   = ST_IDLE;
                    ferr_next    = (bit_cnt_next != '0);
                    bit_cnt_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            word_reg    <= '0;
            pend_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            word_reg    <= word_next;
            pend_reg    <= pend_next;
            ferr_reg    <= ferr_next;
        end
    end

    logic [DATA_W-1:0] dout_reg;
    logic              dout_valid_reg;
    logic              overrun_reg;
    logic              drop_word;

    assign drop_word = pend_reg & dout_valid_reg & ~dout_ready;

    // Output holding register with valid/ready handshake and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (pend_reg && (!dout_valid_reg || dout_ready)) begin
                dout_reg       <= word_reg;
                dout_valid_reg <= 1'b1;
            end else if (dout_valid_reg && dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
            // Setting wins over a simultaneous clear
            if (drop_word) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = ferr_reg;
    assign busy       = (state_reg == ST_SHIFT);
    assign bit_cnt    = bit_cnt_reg;

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Downstream receive stage for the 12-bit SPI master. It takes one bit of the master's one-hot cs bus together with sclk and mosi, and oversamples them on the local system clock. It deserializes MSB-first words and presents each completed word on a valid/ready interface to the slave-side logic. It also detects aborted frames and overrun.

Parameters:
DATA_W, 12, word width in bits; must match the master's din width.
CPOL, 0, sclk idle level; must match the master.
CPHA, 0, clock phase. 0 = sample on the leading edge, 1 = sample on the trailing edge.

Ports:
clk  input  1  system clock; sclk half-period must be at least 2 clk periods
rst_n  input  1  asynchronous active-low reset
cs  input  1  chip select from the master's cs bus; 1 = this slave is selected; asynchronous to clk
sclk  input  1  serial clock from the master; asynchronous to clk
mosi  input  1  serial data, MSB first; asynchronous to clk
dout  output  DATA_W  received word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready at a clk edge
frame_err  output  1  one-cycle pulse when cs deasserts with a partial word
overrun  output  1  sticky flag: a completed word was dropped
overrun_clr  input  1  synchronous clear of overrun
busy  output  1  synchronized cs is asserted
bit_cnt  output  $clog2(DATA_W)  bits received in the current word

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-word):
  - dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0, bit_cnt=0.
  - Shift register cleared; all synchronizer flops loaded with cs=0, sclk=CPOL, mosi=0.
  - FSM goes to IDLE.
- Synchronization:
  - cs, sclk and mosi each pass through 2 flops (s1, s2).
  - A third flop (s3) holds the previous s2 for edge detection.
  - mosi uses the same depth so data stays aligned with sclk.
- Sample edge: sclk rising when CPOL==CPHA, falling otherwise (s2/s3 compare).
- FSM states:
  - IDLE: busy=0. On synchronized cs rising: bit_cnt<=0, shift register<=0, go to SHIFT.
  - SHIFT: busy=1.
    - On each sample edge: shift <= {shift[DATA_W-2:0], mosi_s2}, bit_cnt++.
    - When the shift makes bit_cnt reach DATA_W: bit_cnt wraps to 0 and the word is committed on the next edge. Back-to-back words within one cs assertion are supported.
    - On synchronized cs falling: go to IDLE. If bit_cnt!=0, pulse frame_err for exactly 1 cycle and discard the partial word. If bit_cnt==0, no error.
  - Sample edges are ignored in IDLE.
- Latency: dout/dout_valid update at the 3rd clk edge after the edge where s1 first captures the final sample sclk transition (s1 -> s2 -> shift -> output register).
- Commit rules:
  - If dout_valid==0, or dout_valid && dout_ready in the same cycle: dout <= word, dout_valid <= 1. No overrun.
  - If dout_valid && !dout_ready: word dropped, dout unchanged, overrun <= 1.
  - Accept with no commit: dout_valid <= 0; dout keeps its last value.
- overrun:
  - Set has priority over overrun_clr in the same cycle.
  - Otherwise overrun_clr clears it. It never clears by itself.
- Abort and commit in the same cycle:
  - If cs falling is detected in the same cycle as the final sample edge, the word completes and commits.
  - frame_err is not raised because bit_cnt is 0 after that shift.
- If sclk toggles while cs=0, no state change occurs.

Test Plan:
1. Mode 0, DATA_W=12, dout_ready=1, send 12'hA5C in one cs frame -> one dout_valid pulse with dout=12'hA5C, 3 clk after the final rising sclk capture; frame_err=0, overrun=0.
2. Back-to-back 12'h123 then 12'hFED in one cs assertion, dout_ready=1 -> two commits in order with dout=12'h123 then 12'hFED; bit_cnt returns to 0 after each.
3. cs deasserted after 5 bits of 12'hFFF -> frame_err high for exactly 1 cycle, dout_valid stays 0, next frame 12'h00F received correctly.
4. dout_ready=0, send 12'h111 then 12'h222 -> dout=12'h111, dout_valid=1, overrun=1. Then assert overrun_clr with dout_ready=1 -> overrun=0, dout_valid=0.
5. CPOL=1, CPHA=1, send 12'h800 and 12'h001 -> dout matches both words (sampling on rising edge, idle high).
6. rst_n pulsed low after 7 bits -> all outputs 0 immediately. After release, a full 12'h3C3 frame is received correctly with frame_err=0.
